// File: rtl/mmc3_irq_counter.sv
// MMC3 scanline IRQ counter: counts qualified PPU A12 rises and decodes the $C000-$FFFF IRQ registers.
// Latency: register writes land on the sampling m2 edge; an A12 rise first sampled at edge k updates the counter at k+2.
// Backpressure: none; every m2 falling edge is consumed, and enable low freezes counter/latch/reload and drops the IRQ.
module mmc3_irq_counter #(
  parameter int unsigned LOW_CYCLES = 3
) (
  input  logic        m2,
  input  logic        reset,
  input  logic        enable,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        ppu_a12,
  output wire         irq,
  output logic        irq_pending,
  output logic [7:0]  counter_out
);

  localparam logic [2:0] LOW_MAX = 3'(LOW_CYCLES);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       s3_q, s3_d;
  logic [2:0] low_cnt_q, low_cnt_d;
  logic [7:0] latch_q, latch_d;
  logic [7:0] counter_q, counter_d;
  logic       reload_q, reload_d;
  logic       irq_en_q, irq_en_d;
  logic       irq_pending_q, irq_pending_d;

  logic       wr_stb;
  logic       a12_edge;
  logic       unused_addr;

  // Only A14, A13 and A0 take part in the register decode.
  assign unused_addr = ^cpu_addr_in[12:1];

  // Next-state: synchronizer and low-time filter always run; register writes apply before the edge logic.
  always_comb begin
    s1_d          = ppu_a12;
    s2_d          = s1_q;
    s3_d          = s2_q;
    low_cnt_d     = low_cnt_q;
    latch_d       = latch_q;
    counter_d     = counter_q;
    reload_d      = reload_q;
    irq_en_d      = irq_en_q;
    irq_pending_d = irq_pending_q;

    if (s3_q) begin
      low_cnt_d = 3'd0;
    end else if (low_cnt_q < LOW_MAX) begin
      low_cnt_d = low_cnt_q + 3'd1;
    end

    a12_edge = s2_q && !s3_q && (low_cnt_q >= LOW_MAX);
    wr_stb   = !cpu_rw_in && !romsel && enable;

    if (!enable) begin
      // Counter, latch and reload hold; the IRQ side is dropped so the line releases.
      irq_en_d      = 1'b0;
      irq_pending_d = 1'b0;
    end else begin
      if (wr_stb && cpu_addr_in[14]) begin
        case ({cpu_addr_in[13], cpu_addr_in[0]})
          2'b00: latch_d = cpu_data_in;
          2'b01: begin
            counter_d = 8'd0;
            reload_d  = 1'b1;
          end
          2'b10: begin
            irq_en_d      = 1'b0;
            irq_pending_d = 1'b0;
          end
          default: irq_en_d = 1'b1;
        endcase
      end

      // The edge sees the post-write latch/reload/irq_en, so a coincident $E000 suppresses the hit.
      if (a12_edge) begin
        if (counter_d == 8'd0 || reload_d) begin
          counter_d = latch_d;
          reload_d  = 1'b0;
        end else begin
          counter_d = counter_d - 8'd1;
        end
        if (counter_d == 8'd0 && irq_en_d) begin
          irq_pending_d = 1'b1;
        end
      end
    end
  end

  // State register on the falling edge of m2 with synchronous reset.
  always_ff @(negedge m2) begin
    if (reset) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      low_cnt_q     <= 3'd0;
      latch_q       <= 8'd0;
      counter_q     <= 8'd0;
      reload_q      <= 1'b0;
      irq_en_q      <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      low_cnt_q     <= low_cnt_d;
      latch_q       <= latch_d;
      counter_q     <= counter_d;
      reload_q      <= reload_d;
      irq_en_q      <= irq_en_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign irq         = irq_pending_q ? 1'b0 : 1'bz;
  assign irq_pending = irq_pending_q;
  assign counter_out = counter_q;

endmodule

// File: tb/tb_mmc3_irq_counter.sv
// Testbench for mmc3_irq_counter: directed scenarios followed by randomized bus and A12 traffic.
// Each m2 cycle pushes the reference model's expected state; a monitor pops and compares after every falling edge.
// The open-drain irq line is pulled up here, so released reads as 1.
module tb_mmc3_irq_counter;

  localparam int LOW_CYCLES = 3;

  logic        m2 = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        romsel = 1'b1;
  logic        cpu_rw_in = 1'b1;
  logic [14:0] cpu_addr_in = '0;
  logic [7:0]  cpu_data_in = '0;
  logic        ppu_a12 = 1'b0;
  wire         irq_w;
  logic        irq_pending;
  logic [7:0]  counter_out;

  pullup (irq_w);

  mmc3_irq_counter #(.LOW_CYCLES(LOW_CYCLES)) dut (
    .m2          (m2),
    .reset       (reset),
    .enable      (enable),
    .romsel      (romsel),
    .cpu_rw_in   (cpu_rw_in),
    .cpu_addr_in (cpu_addr_in),
    .cpu_data_in (cpu_data_in),
    .ppu_a12     (ppu_a12),
    .irq         (irq_w),
    .irq_pending (irq_pending),
    .counter_out (counter_out)
  );

  always #5 m2 = ~m2;

  typedef struct packed {
    logic [7:0] cnt;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: plain integers and the history of A12 samples since reset.
  int m_latch = 0, m_counter = 0, m_reload = 0, m_irq_en = 0, m_pend = 0;
  bit hist[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // One falling edge of m2. A rise is qualified when the synchronized sample two edges back is
  // high, three back is low, and the low stretch that has passed through the whole synchronizer
  // before that is at least LOW_CYCLES samples long. Samples before reset count as neither.
  task automatic model_step(input logic rst, input logic en, input logic rs, input logic rw,
                            input logic [14:0] addr, input logic [7:0] d, input logic a12);
    int n, run;
    bit qual;
    if (rst) begin
      m_latch = 0; m_counter = 0; m_reload = 0; m_irq_en = 0; m_pend = 0;
      hist.delete();
      repeat (3) hist.push_back(1'b0);
      return;
    end
    hist.push_back(a12);
    n = hist.size() - 1;
    run = 0;
    for (int i = n - 4; i >= 0 && run < LOW_CYCLES; i--) begin
      if (hist[i]) break;
      run++;
    end
    qual = hist[n-2] && !hist[n-3] && (run >= LOW_CYCLES);
    if (!en) begin
      m_irq_en = 0;
      m_pend = 0;
    end else begin
      if (!rw && !rs) begin
        case ({addr[14:13], addr[0]})
          3'b100: m_latch = int'(d);
          3'b101: begin m_counter = 0; m_reload = 1; end
          3'b110: begin m_irq_en = 0; m_pend = 0; end
          3'b111: m_irq_en = 1;
          default: ;
        endcase
      end
      if (qual) begin
        if (m_counter == 0 || m_reload != 0) begin
          m_counter = m_latch;
          m_reload = 0;
        end else begin
          m_counter = m_counter - 1;
        end
        if (m_counter == 0 && m_irq_en != 0) m_pend = 1;
      end
    end
  endtask

  // Drive one cycle of inputs on the rising edge and record what the next falling edge must produce.
  task automatic cycle(input logic rst, input logic en, input logic rs, input logic rw,
                       input logic [14:0] addr, input logic [7:0] d, input logic a12);
    exp_t e;
    @(posedge m2);
    reset = rst; enable = en; romsel = rs; cpu_rw_in = rw;
    cpu_addr_in = addr; cpu_data_in = d; ppu_a12 = a12;
    model_step(rst, en, rs, rw, addr, d, a12);
    e.cnt = 8'(m_counter);
    e.pend = (m_pend != 0);
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, a[14:0], d, 1'b0);
  endtask

  task automatic idle(input int n, input logic en, input logic a12);
    for (int i = 0; i < n; i++) cycle(1'b0, en, 1'b1, 1'b1, 15'h0, 8'h0, a12);
  endtask

  task automatic pulse(input int gap, input int hi, input logic en);
    idle(gap, en, 1'b0);
    idle(hi, en, 1'b1);
  endtask

  // Monitor: compares the DUT against the queued expectation just after every falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge m2);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("counter_out", int'(counter_out), int'(e.cnt));
        check("irq_pending", int'(irq_pending), int'(e.pend));
        check("irq_line", int'(irq_w === 1'b1), e.pend ? 0 : 1);
      end
    end
  end

  // Stimulus.
  initial begin
    logic       a12_lvl;
    int         a12_left;
    logic [1:0] sel;
    logic [7:0] d;
    int         budget;

    // Reset for two cycles while A12 toggles.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 15'h0, 8'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 15'h0, 8'h0, 1'b0);
    idle(6, 1'b1, 1'b0);

    // Latch 3, reload, enable, then four qualified pulses: 3, 2, 1, 0 and IRQ.
    wr(16'hC000, 8'd3);
    wr(16'hC001, 8'd0);
    wr(16'hE001, 8'd0);
    repeat (4) pulse(6, 2, 1'b1);
    idle(4, 1'b1, 1'b0);

    // Acknowledge, then a fifth pulse reloads 3 with the IRQ still released.
    wr(16'hE000, 8'd0);
    pulse(6, 2, 1'b1);
    idle(4, 1'b1, 1'b0);

    // Short low gaps are ignored; a long one counts.
    pulse(1, 2, 1'b1);
    pulse(2, 2, 1'b1);
    pulse(3, 2, 1'b1);
    pulse(LOW_CYCLES + 1, 2, 1'b1);
    idle(4, 1'b1, 1'b0);

    // latch = 0: every qualified edge hits zero; an $E000 on the same edge wins.
    wr(16'hC000, 8'd0);
    wr(16'hC001, 8'd0);
    wr(16'hE001, 8'd0);
    pulse(6, 2, 1'b1);
    idle(4, 1'b1, 1'b0);
    wr(16'hE001, 8'd0);
    pulse(6, 2, 1'b1);
    wr(16'hE000, 8'd0);
    idle(4, 1'b1, 1'b0);

    // Count from 5, drop enable mid-count, re-enable, then reset on an A12 rise.
    wr(16'hC000, 8'd5);
    wr(16'hC001, 8'd0);
    wr(16'hE001, 8'd0);
    repeat (2) pulse(6, 2, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 15'h6001, 8'h0, 1'b0);
    repeat (2) pulse(6, 2, 1'b0);
    idle(3, 1'b1, 1'b0);
    wr(16'hE001, 8'd0);
    pulse(6, 2, 1'b1);
    idle(4, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 15'h0, 8'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 15'h6001, 8'h0, 1'b1);
    idle(6, 1'b1, 1'b0);

    // Randomized traffic: A12 runs of 1..6 low and 1..3 high, sparse register writes,
    // occasional enable drops and rare resets.
    a12_lvl = 1'b0;
    a12_left = 6;
    for (int i = 0; i < 2000; i++) begin
      logic en, rst, rs, rw;
      logic [14:0] addr;
      if (a12_left == 0) begin
        a12_lvl = ~a12_lvl;
        a12_left = a12_lvl ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 6));
      end
      a12_left--;
      en  = ($urandom_range(0, 29) != 0);
      rst = ($urandom_range(0, 299) == 0);
      rs  = 1'b1;
      rw  = 1'b1;
      addr = 15'($urandom);
      d = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 5) == 0) begin
        sel = 2'($urandom);
        rs = ($urandom_range(0, 7) == 0);
        rw = ($urandom_range(0, 7) == 0);
        addr = {sel[1], ($urandom_range(0, 3) != 0), 12'($urandom), sel[0]};
      end
      cycle(rst, en, rs, rw, addr, d, a12_lvl);
    end
    idle(2, 1'b1, 1'b0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge m2);
      budget++;
    end
    @(negedge m2);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
